cim_psum_decode_acc: RTL and testbench

- Streaming successor to the combinational CIM partial-sum decoder. Each beat carries one 5-bit code per channel per macro; the block decodes each code to a signed 4-bit value and sums across the macros in every channel.
- It then accumulates ACC_LEN beats per frame, either as a plain sum or as bit-serial MSB-first activation weighting, and emits one saturated ACC_W-bit result per channel.
- Sits between the macro partial-sum outputs and the BN/activation stage, with valid/ready handshakes on both sides.

---
 rtl/cim_psum_decode_acc_if.sv | 27 ++
 rtl/cim_psum_decode_acc.sv | 181 ++++++++++++++++++
 tb/tb_cim_psum_decode_acc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cim_psum_decode_acc_if.sv
// Handshake bundle between macro partial-sum codes, the decode/accumulate block and the BN stage.
// The master drives beats and consumes results; the slave is the accumulator.
interface cim_psum_decode_acc_if #(
  parameter int CHANNEL_NUM = 128,
  parameter int MACRO_NUM   = 4,
  parameter int ACC_W       = 16
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic                                    in_mode;
  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][4:0] data_in;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [CHANNEL_NUM-1:0][ACC_W-1:0]       data_out;
  logic                                    out_err;
  logic                                    out_sat;

  modport master (
    output in_valid, in_mode, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_err, out_sat
  );

  modport slave (
    input  in_valid, in_mode, data_in, out_ready,
    output in_ready, out_valid, data_out, out_err, out_sat
  );
endinterface

// File: rtl/cim_psum_decode_acc.sv
// Decodes CIM codes, sums macros, accumulates ACC_LEN beats per frame; result 2 cycles after last beat.
// Only a last beat facing a full, undrained output register stalls; other beats keep flowing.
module cim_psum_decode_acc #(
  parameter int CHANNEL_NUM = 128,
  parameter int MACRO_NUM   = 4,
  parameter int ACC_LEN     = 8,
  parameter int ACC_W       = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  cim_psum_decode_acc_if.slave  io_bus
);

  localparam int S_W   = 4 + $clog2(MACRO_NUM);
  localparam int A_W   = ACC_W + 2;
  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(ACC_LEN - 1);
  localparam logic signed [A_W-1:0] SAT_MAX  = A_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [A_W-1:0] SAT_MIN  = ~SAT_MAX;

  // Returns {illegal, value[3:0]}; illegal codes contribute 0.
  function automatic logic [4:0] f_decode(input logic [4:0] code);
    case (code)
      5'b00000: f_decode = {1'b0, 4'h8};
      5'b00001: f_decode = {1'b0, 4'h9};
      5'b00010: f_decode = {1'b0, 4'hA};
      5'b00100: f_decode = {1'b0, 4'hB};
      5'b01000: f_decode = {1'b0, 4'hC};
      5'b10000: f_decode = {1'b0, 4'hD};
      5'b10001: f_decode = {1'b0, 4'hE};
      5'b10010: f_decode = {1'b0, 4'hF};
      5'b10100: f_decode = {1'b0, 4'h0};
      5'b11000: f_decode = {1'b0, 4'h1};
      5'b11001: f_decode = {1'b0, 4'h2};
      5'b11010: f_decode = {1'b0, 4'h3};
      5'b11100: f_decode = {1'b0, 4'h4};
      5'b11101: f_decode = {1'b0, 4'h5};
      5'b11110: f_decode = {1'b0, 4'h6};
      5'b11111: f_decode = {1'b0, 4'h7};
      default:  f_decode = {1'b1, 4'h0};
    endcase
  endfunction

  logic                         r_rst_done;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_frame_mode;
  logic                         r_s1_vld;
  logic signed [S_W-1:0]        r_s1_sum [CHANNEL_NUM];
  logic                         r_s1_err;
  logic [CNT_W-1:0]             r_s1_idx;
  logic                         r_s1_mode;
  logic signed [A_W-1:0]        r_acc [CHANNEL_NUM];
  logic                         r_acc_err;
  logic                         r_out_vld;
  logic [CHANNEL_NUM-1:0][ACC_W-1:0] r_out_dat;
  logic                         r_out_err;
  logic                         r_out_sat;

  logic signed [S_W-1:0]        w_sum [CHANNEL_NUM];
  logic                         w_ill;
  logic                         w_beat_mode;
  logic                         w_s1_last;
  logic                         w_out_free;
  logic                         w_s1_adv;
  logic                         w_in_rdy;
  logic                         w_in_fire;
  logic signed [A_W-1:0]        w_acc_nxt [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0][ACC_W-1:0] w_clamp;
  logic                         w_any_sat;
  logic                         w_err_nxt;

  always_comb begin
    logic [4:0]            w_dec;
    logic signed [S_W-1:0] w_part;
    w_ill = 1'b0;
    for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
      w_part = '0;
      for (int m = 0; m < MACRO_NUM; m++) begin
        w_dec  = f_decode(io_bus.data_in[ch][m]);
        w_ill  = w_ill | w_dec[4];
        w_part = w_part + S_W'($signed(w_dec[3:0]));
      end
      w_sum[ch] = w_part;
    end
  end

  assign w_beat_mode = (r_cnt == '0) ? io_bus.in_mode : r_frame_mode;
  assign w_s1_last   = (r_s1_idx == LAST_IDX);
  assign w_out_free  = !r_out_vld || io_bus.out_ready;
  assign w_s1_adv    = r_s1_vld && (!w_s1_last || w_out_free);
  assign w_in_rdy    = r_rst_done && (!r_s1_vld || w_s1_adv);
  assign w_in_fire   = io_bus.in_valid && w_in_rdy;

  // Beat 0 seeds the accumulator; bit-serial mode gives the MSB beat negative weight.
  always_comb begin
    logic signed [A_W-1:0] w_ext;
    w_any_sat = 1'b0;
    w_err_nxt = (r_s1_idx == '0) ? r_s1_err : (r_acc_err | r_s1_err);
    for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
      w_ext = A_W'(r_s1_sum[ch]);
      if (r_s1_idx == '0) begin
        w_acc_nxt[ch] = r_s1_mode ? -w_ext : w_ext;
      end else begin
        w_acc_nxt[ch] = r_s1_mode ? ((r_acc[ch] <<< 1) + w_ext) : (r_acc[ch] + w_ext);
      end
      if (w_acc_nxt[ch] > SAT_MAX) begin
        w_clamp[ch] = SAT_MAX[ACC_W-1:0];
        w_any_sat   = 1'b1;
      end else if (w_acc_nxt[ch] < SAT_MIN) begin
        w_clamp[ch] = SAT_MIN[ACC_W-1:0];
        w_any_sat   = 1'b1;
      end else begin
        w_clamp[ch] = w_acc_nxt[ch][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_done   <= 1'b0;
      r_cnt        <= '0;
      r_frame_mode <= 1'b0;
      r_s1_vld     <= 1'b0;
      r_s1_err     <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_mode    <= 1'b0;
      for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
        r_s1_sum[ch] <= '0;
      end
    end else begin
      r_rst_done <= 1'b1;
      if (w_in_fire) begin
        r_cnt     <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
        r_s1_vld  <= 1'b1;
        r_s1_sum  <= w_sum;
        r_s1_err  <= w_ill;
        r_s1_idx  <= r_cnt;
        r_s1_mode <= w_beat_mode;
        if (r_cnt == '0) begin
          r_frame_mode <= io_bus.in_mode;
        end
      end else if (w_s1_adv) begin
        r_s1_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc_err <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_err <= 1'b0;
      r_out_sat <= 1'b0;
      for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
        r_acc[ch] <= '0;
      end
    end else begin
      if (w_s1_adv) begin
        r_acc     <= w_acc_nxt;
        r_acc_err <= w_err_nxt;
      end
      // A load may coincide with a drain; the new result then simply replaces the old one.
      if (w_s1_adv && w_s1_last) begin
        r_out_vld <= 1'b1;
        r_out_dat <= w_clamp;
        r_out_err <= w_err_nxt;
        r_out_sat <= w_any_sat;
      end else if (r_out_vld && io_bus.out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_rdy;
  assign io_bus.out_valid = r_out_vld;
  assign io_bus.data_out  = r_out_dat;
  assign io_bus.out_err   = r_out_err;
  assign io_bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_cim_psum_decode_acc.sv
// Directed bench: frame table on a 16-bit and an 8-bit accumulator in lockstep, then backpressure and reset sequences.
module tb_cim_psum_decode_acc;

  localparam int CH = 128;
  localparam int MN = 4;
  localparam int AL = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cim_psum_decode_acc_if #(.CHANNEL_NUM(CH), .MACRO_NUM(MN), .ACC_W(16)) bus16 ();
  cim_psum_decode_acc_if #(.CHANNEL_NUM(CH), .MACRO_NUM(MN), .ACC_W(8))  bus8 ();

  cim_psum_decode_acc #(.CHANNEL_NUM(CH), .MACRO_NUM(MN), .ACC_LEN(AL), .ACC_W(16)) dut16 (
    .clk(clk), .rstn(rstn), .io_bus(bus16)
  );
  cim_psum_decode_acc #(.CHANNEL_NUM(CH), .MACRO_NUM(MN), .ACC_LEN(AL), .ACC_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .io_bus(bus8)
  );

  assign bus8.in_valid  = bus16.in_valid;
  assign bus8.in_mode   = bus16.in_mode;
  assign bus8.data_in   = bus16.data_in;
  assign bus8.out_ready = bus16.out_ready;

  typedef struct {
    logic       mode;
    logic [4:0] c0;
    logic [4:0] cr;
    int         bad;
    int         e16;
    logic       err;
    logic       c8;
    int         e8;
    logic       s8;
  } vec_t;

  vec_t vt [14];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int dat16(input int exp);
    for (int ch = 0; ch < CH; ch++)
      if (int'($signed(bus16.data_out[ch])) != exp) return int'($signed(bus16.data_out[ch]));
    return exp;
  endfunction

  function automatic int dat8(input int exp);
    for (int ch = 0; ch < CH; ch++)
      if (int'($signed(bus8.data_out[ch])) != exp) return int'($signed(bus8.data_out[ch]));
    return exp;
  endfunction

  // Beat 0 drives the frame mode, later beats the opposite mode, which the DUT must ignore.
  task automatic send_frame(input logic mode, input logic [4:0] c0, input logic [4:0] cr,
                            input int bad, input int nb);
    int wait_n;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.in_mode  = (b == 0) ? mode : ~mode;
      for (int ch = 0; ch < CH; ch++)
        for (int m = 0; m < MN; m++)
          bus16.data_in[ch][m] = (b == 0) ? c0 : cr;
      if (b == bad) bus16.data_in[5][2] = 5'b00011;
      #1;
      wait_n = 0;
      while (!bus16.in_ready && wait_n < 100) begin
        @(negedge clk);
        #1;
        wait_n++;
      end
      if (wait_n >= 100) begin
        chk("in_ready_timeout", int'(bus16.in_ready), 1);
        bus16.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      n_acc++;
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus16.out_valid && n < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int got;
    int exp_bp [3];
    int ext_cnt;

    vt[0]  = '{1'b0, 5'b11111, 5'b11111, -1,  224, 1'b0, 1'b1,  127, 1'b1};
    vt[1]  = '{1'b1, 5'b11111, 5'b11111, -1,  -28, 1'b0, 1'b1,  -28, 1'b0};
    vt[2]  = '{1'b1, 5'b10100, 5'b11111, -1, 3556, 1'b0, 1'b0,    0, 1'b0};
    vt[3]  = '{1'b0, 5'b10100, 5'b10100,  3,    0, 1'b1, 1'b1,    0, 1'b0};
    vt[4]  = '{1'b0, 5'b10100, 5'b10100, -1,    0, 1'b0, 1'b1,    0, 1'b0};
    vt[5]  = '{1'b0, 5'b00000, 5'b00000, -1, -256, 1'b0, 1'b1, -128, 1'b1};
    vt[6]  = '{1'b0, 5'b00001, 5'b11101, -1,  112, 1'b0, 1'b1,  112, 1'b0};
    vt[7]  = '{1'b0, 5'b00010, 5'b11110, -1,  144, 1'b0, 1'b1,  127, 1'b1};
    vt[8]  = '{1'b0, 5'b00100, 5'b11010, -1,   64, 1'b0, 1'b1,   64, 1'b0};
    vt[9]  = '{1'b0, 5'b01000, 5'b11001, -1,   40, 1'b0, 1'b1,   40, 1'b0};
    vt[10] = '{1'b0, 5'b10000, 5'b11100, -1,  100, 1'b0, 1'b1,  100, 1'b0};
    vt[11] = '{1'b0, 5'b10001, 5'b10010, -1,  -36, 1'b0, 1'b1,  -36, 1'b0};
    vt[12] = '{1'b1, 5'b10010, 5'b10100, -1,  512, 1'b0, 1'b0,    0, 1'b0};
    vt[13] = '{1'b0, 5'b10010, 5'b11000, -1,   24, 1'b0, 1'b1,   24, 1'b0};
    exp_bp = '{32, 64, 96};

    bus16.in_valid  = 1'b0;
    bus16.in_mode   = 1'b0;
    bus16.data_in   = '0;
    bus16.out_ready = 1'b1;

    #2;
    chk("rst_in_ready", int'(bus16.in_ready), 0);
    chk("rst_out_valid", int'(bus16.out_valid), 0);
    chk("rst_data", dat16(0), 0);
    chk("rst_err_sat", int'({bus16.out_err, bus16.out_sat}), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(bus16.in_ready), 1);

    for (int i = 0; i < 14; i++) begin
      send_frame(vt[i].mode, vt[i].c0, vt[i].cr, vt[i].bad, AL);
      #1 bus16.in_valid = 1'b0;
      wait_out(n);
      chk($sformatf("v%0d_latency", i), n, 2);
      chk($sformatf("v%0d_data16", i), dat16(vt[i].e16), vt[i].e16);
      chk($sformatf("v%0d_err16", i), int'(bus16.out_err), int'(vt[i].err));
      chk($sformatf("v%0d_sat16", i), int'(bus16.out_sat), 0);
      if (vt[i].c8) begin
        chk($sformatf("v%0d_data8", i), dat8(vt[i].e8), vt[i].e8);
        chk($sformatf("v%0d_sat8", i), int'(bus8.out_sat), int'(vt[i].s8));
        chk($sformatf("v%0d_err8", i), int'(bus8.out_err), int'(vt[i].err));
      end
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), int'(bus16.out_valid), 0);
    end

    // Three frames against a blocked output.
    bus16.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send_frame(1'b0, 5'b11000, 5'b11000, -1, AL);
        send_frame(1'b0, 5'b11001, 5'b11001, -1, AL);
        send_frame(1'b0, 5'b11010, 5'b11010, -1, AL);
        #1 bus16.in_valid = 1'b0;
      end
      begin
        repeat (20) @(negedge clk);
        chk("bp_beats_accepted", n_acc, 16);
        chk("bp_in_ready_low", int'(bus16.in_ready), 0);
        chk("bp_hold_valid", int'(bus16.out_valid), 1);
        chk("bp_hold_data", dat16(32), 32);
        bus16.out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && got < 3; k++) begin
          if (bus16.out_valid) begin
            chk($sformatf("bp_result%0d", got), dat16(exp_bp[got]), exp_bp[got]);
            got++;
          end
          @(negedge clk);
        end
        chk("bp_result_count", got, 3);
      end
    join
    chk("bp_total_beats", n_acc, 24);

    // Reset in the middle of a frame while a result is held.
    @(negedge clk);
    bus16.out_ready = 1'b0;
    send_frame(1'b0, 5'b11111, 5'b11111, -1, AL);
    send_frame(1'b0, 5'b11111, 5'b11111, -1, 4);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    chk("pre_rst_valid", int'(bus16.out_valid), 1);
    chk("pre_rst_data", dat16(224), 224);
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(bus16.in_ready), 0);
    chk("mid_rst_out_valid", int'(bus16.out_valid), 0);
    chk("mid_rst_data16", dat16(0), 0);
    chk("mid_rst_data8", dat8(0), 0);
    chk("mid_rst_err_sat", int'({bus16.out_err, bus16.out_sat}), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus16.in_ready), 1);
    send_frame(1'b0, 5'b11000, 5'b11000, -1, AL);
    #1 bus16.in_valid = 1'b0;
    wait_out(n);
    chk("post_rst_latency", n, 2);
    chk("post_rst_data", dat16(32), 32);
    ext_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus16.out_valid) ext_cnt++;
    end
    chk("post_rst_no_extra", ext_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
